// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU defines for the fetch stage: reset/exception vectors, FSM encoding and
// the word type carried from the instruction port to decode.
package fetch_ctrl_pkg;

    localparam logic [31:0] FC_RESET_PC   = 32'hbfc0_0000;
    localparam logic [31:0] FC_EXC_VECTOR = 32'hbfc0_0380;
    localparam logic [31:0] FC_INST_STEP  = 32'd4;

    typedef enum logic [1:0] {
        StBoot    = 2'd0,
        StReq     = 2'd1,
        StWait    = 2'd2,
        StDiscard = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + FC_INST_STEP;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage signal bundle: redirects from decode/exception logic, the SRAM-like
// instruction port, and the registered fetch output towards decode.
interface fetch_ctrl_if;

    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        input  stall, br_taken, br_target, flush, flush_pc,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output inst_req, inst_addr, if_valid, if_pc, if_inst
    );

    modport slave (
        output stall, br_taken, br_target, flush, flush_pc,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  inst_req, inst_addr, if_valid, if_pc, if_inst
    );

endinterface

// File: rtl/fetch_buf.sv
// One-entry skid buffer behind the fetch output slot; only instantiated when
// FETCH_INST_BUF_EN is defined.
module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  fetch_word_t i_word,
    input  logic        i_pop,
    output logic        o_valid,
    output fetch_word_t o_word
);

    logic        r_valid;
    fetch_word_t r_word;

    // A push in the same cycle as a pop refills the entry rather than emptying it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like request, redirect handling
// and a registered output slot. FETCH_INST_BUF_EN adds a one-entry skid buffer.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FC_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  io_fetch
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_valid;
    fetch_word_t  r_slot;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_consume;
    logic         w_slot_free;
    logic         w_hold;
    logic         w_deliver;
    logic         w_buf_valid;
    fetch_word_t  w_buf_word;
    fetch_word_t  w_rx_word;

    assign w_redirect  = io_fetch.flush | (io_fetch.br_taken & ~io_fetch.stall);
    assign w_target    = io_fetch.flush ? io_fetch.flush_pc : io_fetch.br_target;
    assign w_consume   = r_valid & ~io_fetch.stall;
    assign w_slot_free = ~r_valid | w_consume;
    assign w_rx_word   = '{pc: r_pc, inst: io_fetch.inst_rdata};

`ifdef FETCH_INST_BUF_EN
    logic w_buf_push;

    assign w_hold     = w_buf_valid;
    // New data goes to the buffer if the slot stays busy or the buffer is draining into it.
    assign w_buf_push = w_deliver & (~w_slot_free | w_buf_valid);

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_redirect),
        .i_push  (w_buf_push),
        .i_word  (w_rx_word),
        .i_pop   (w_consume),
        .o_valid (w_buf_valid),
        .o_word  (w_buf_word)
    );
`else
    // Without a buffer a stalled full slot must not have a request behind it.
    assign w_hold      = r_valid & io_fetch.stall;
    assign w_buf_valid = 1'b0;
    assign w_buf_word  = '0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_deliver         = 1'b0;
        io_fetch.inst_req = 1'b0;
        unique case (r_state)
            StBoot: w_state_nxt = StReq;
            StReq: begin
                io_fetch.inst_req = ~w_hold;
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = (~w_hold & io_fetch.inst_addr_ok) ? StDiscard : StReq;
                end else if (~w_hold & io_fetch.inst_addr_ok) begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = io_fetch.inst_data_ok ? StReq : StDiscard;
                end else if (io_fetch.inst_data_ok) begin
                    w_deliver   = 1'b1;
                    w_pc_nxt    = next_pc(r_pc);
                    w_state_nxt = StReq;
                end
            end
            StDiscard: begin
                if (w_redirect) w_pc_nxt = w_target;
                if (io_fetch.inst_data_ok) w_state_nxt = StReq;
            end
            default: w_state_nxt = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StBoot;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_redirect) begin
                r_valid <= 1'b0;
            end else if (w_slot_free) begin
                if (w_buf_valid) begin
                    r_valid <= 1'b1;
                    r_slot  <= w_buf_word;
                end else if (w_deliver) begin
                    r_valid <= 1'b1;
                    r_slot  <= w_rx_word;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign io_fetch.inst_addr = r_pc;
    assign io_fetch.if_valid  = r_valid;
    assign io_fetch.if_pc     = r_slot.pc;
    assign io_fetch.if_inst   = r_slot.inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected requests and
// words; a monitor pops and compares on every accepted request and consumed word.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'hbfc0_0000)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

`ifdef FETCH_INST_BUF_EN
    localparam int StallFires = 1;
`else
    localparam int StallFires = 0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];

    // Memory responder state: grants = number of requests still to accept.
    int          grants = 0;
    int          lat    = 1;
    bit          pend   = 1'b0;
    int          cnt    = 0;
    logic [31:0] paddr  = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit with_data);
        exp_addr.push_back(a);
        if (with_data) exp_data.push_back({a, ~a});
    endtask

    task automatic drain();
        int n = 0;
        while ((grants > 0 || pend || exp_addr.size() != 0 || exp_data.size() != 0) && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 80) begin
            failures++;
            $display("FAIL drain: %0d requests and %0d words still pending, required 0",
                     exp_addr.size(), exp_data.size());
        end
        step();
    endtask

    // Instruction memory: accepts while grants remain, returns ~addr after lat cycles.
    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_req && bus.inst_addr_ok) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.inst_addr;
                grants--;
            end
            @(posedge clk);
            #2;
            bus.inst_data_ok = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = ~paddr;
                    pend             = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.inst_addr_ok = (grants > 0);
        end
    end

    // Monitor
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_req && bus.inst_addr_ok) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_addr: got request to %08h, required none", bus.inst_addr);
                end else begin
                    check32("req_addr", bus.inst_addr, exp_addr.pop_front());
                end
            end
            if (!rst && bus.if_valid && !bus.stall) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL if_word: got pc %08h inst %08h, required no word",
                             bus.if_pc, bus.if_inst);
                end else begin
                    e = exp_data.pop_front();
                    check32("if_pc", bus.if_pc, e[63:32]);
                    check32("if_inst", bus.if_inst, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        int n_fire;
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;

        // Reset state, dead BOOT cycle, then a three-word stream.
        grants = 3;
        lat    = 1;
        expect_fetch(32'hbfc0_0000, 1'b1);
        expect_fetch(32'hbfc0_0004, 1'b1);
        expect_fetch(32'hbfc0_0008, 1'b1);
        step();
        step();
        @(negedge clk);
        check1("rst_inst_req", bus.inst_req, 1'b0);
        check32("rst_inst_addr", bus.inst_addr, 32'hbfc0_0000);
        check1("rst_if_valid", bus.if_valid, 1'b0);
        check32("rst_if_pc", bus.if_pc, 32'h0);
        check32("rst_if_inst", bus.if_inst, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check1("boot_dead_cycle", bus.inst_req, 1'b0);
        @(negedge clk);
        check1("first_req", bus.inst_req, 1'b1);
        drain();
        @(negedge clk);
        check32("pc_after_stream", bus.inst_addr, 32'hbfc0_000c);

        // Branch in WAIT together with data_ok: word dropped, redirect next cycle.
        step();
        grants = 1;
        expect_fetch(32'hbfc0_000c, 1'b0);
        step();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hbfc0_0100;
        step();
        bus.br_taken = 1'b0;
        @(negedge clk);
        check32("br_redirect_addr", bus.inst_addr, 32'hbfc0_0100);
        check1("br_redirect_req", bus.inst_req, 1'b1);
        check1("br_slot_empty", bus.if_valid, 1'b0);
        step();
        grants = 2;
        expect_fetch(32'hbfc0_0100, 1'b1);
        expect_fetch(32'hbfc0_0104, 1'b1);
        drain();

        // Flush under stall while the request is accepted: DISCARD drops the reply.
        lat = 3;
        step();
        grants       = 1;
        bus.stall    = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hbfc0_0380;
        expect_fetch(32'hbfc0_0108, 1'b0);
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        check1("discard_no_req", bus.inst_req, 1'b0);
        check32("discard_new_pc", bus.inst_addr, 32'hbfc0_0380);
        step();
        lat    = 1;
        grants = 1;
        expect_fetch(32'hbfc0_0380, 1'b1);
        drain();

        // Five-cycle stall with a full slot.
        step();
        grants = 3;
        expect_fetch(32'hbfc0_0384, 1'b1);
        expect_fetch(32'hbfc0_0388, 1'b1);
        expect_fetch(32'hbfc0_038c, 1'b1);
        step();
        step();
        bus.stall = 1'b1;
        n_req     = 0;
        n_fire    = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check1("stall_slot_full", bus.if_valid, 1'b1);
            if (bus.inst_req) n_req++;
            if (bus.inst_req && bus.inst_addr_ok) n_fire++;
            step();
        end
        bus.stall = 1'b0;
        check32("stall_req_cycles", n_req, StallFires);
        check32("stall_accepts", n_fire, StallFires);
        drain();

        // Redirect in REQ without addr_ok, then pc wrap past ffff_fffc.
        step();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hffff_fffc;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check32("req_redirect_addr", bus.inst_addr, 32'hffff_fffc);
        check1("req_redirect_req", bus.inst_req, 1'b1);
        step();
        grants = 2;
        expect_fetch(32'hffff_fffc, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        drain();

        // Reset during WAIT; the stale reply lands in BOOT.
        lat = 2;
        step();
        grants = 1;
        expect_fetch(32'h0000_0004, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        lat = 1;
        @(negedge clk);
        check1("rst_wait_boot_req", bus.inst_req, 1'b0);
        check32("rst_wait_pc", bus.inst_addr, 32'hbfc0_0000);
        check1("rst_wait_if_valid", bus.if_valid, 1'b0);
        check32("rst_wait_if_pc", bus.if_pc, 32'h0);
        step();
        grants = 2;
        expect_fetch(32'hbfc0_0000, 1'b1);
        expect_fetch(32'hbfc0_0004, 1'b1);
        drain();

        // Branch ignored under stall; flush wins over a simultaneous branch.
        step();
        bus.stall     = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1234_5678;
        step();
        bus.stall    = 1'b0;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hbfc0_0200;
        @(negedge clk);
        check32("br_ignored_stalled", bus.inst_addr, 32'hbfc0_0008);
        step();
        bus.flush    = 1'b0;
        bus.br_taken = 1'b0;
        @(negedge clk);
        check32("flush_over_br", bus.inst_addr, 32'hbfc0_0200);
        step();
        grants = 1;
        expect_fetch(32'hbfc0_0200, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000: the first fetch address after reset SHALL be this value.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-005 br_taken  in  1  decode-stage branch/jump redirect; br_target  in  32  its target.
REQ-006 flush  in  1  exception/eret redirect; flush_pc  in  32  its target.
REQ-007 inst_req  out  1; inst_addr  out  32  instruction SRAM-like request and address.
REQ-008 inst_addr_ok  in  1  request accepted; inst_data_ok  in  1  data returned; inst_rdata  in  32  returned word.
REQ-009 if_valid  out  1; if_pc  out  32; if_inst  out  32  registered fetch output to decode.

Function
REQ-010 Redirect priority SHALL be flush over br_taken; br_taken SHALL be honoured only when stall=0; flush SHALL be honoured regardless of stall.
REQ-011 FSM states SHALL be BOOT, REQ, WAIT, DISCARD; at most one request SHALL be outstanding.
REQ-012 BOOT: inst_req=0; next state SHALL be REQ (one dead cycle after rst deasserts); inst_data_ok in BOOT SHALL be ignored.
REQ-013 REQ: inst_req=1 with inst_addr=fetch pc, gated per REQ-021; on inst_addr_ok -> WAIT.
REQ-014 Redirect in REQ without inst_addr_ok: fetch pc <= target, stay in REQ, and the new address SHALL appear next cycle.
REQ-015 Redirect in REQ with inst_addr_ok in the same cycle: fetch pc <= target, -> DISCARD.
REQ-016 WAIT: on inst_data_ok, load {fetch pc, inst_rdata} into the output slot, fetch pc <= fetch pc + 4 (mod 2^32), -> REQ.
REQ-017 Redirect in WAIT, including in the same cycle as inst_data_ok: returned data SHALL be dropped; -> DISCARD if data is still pending, otherwise -> REQ; fetch pc <= target.
REQ-018 DISCARD: drop the next inst_data_ok, then -> REQ; a further redirect in DISCARD SHALL only update the fetch pc.
REQ-019 The output slot SHALL be consumed when if_valid=1 and stall=0; if_valid SHALL fall the cycle after consumption unless it is refilled in the same cycle.
REQ-020 Any honoured redirect SHALL clear if_valid (and the buffer, when present) on the next edge.
REQ-021 Without the buffer, inst_req SHALL be held 0 while if_valid=1 and stall=1.
REQ-022 Data arriving in the cycle the output slot is consumed SHALL load into the slot with no bubble.

Reset
REQ-023 On rst=1: state=BOOT, fetch pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, buffer empty.
REQ-024 Reset asserted mid-transaction SHALL abandon the outstanding request without waiting for inst_data_ok.

Configuration
REQ-025 Macro FETCH_INST_BUF_EN defined: a one-entry buffer SHALL be added; requests are issued while the slot is stalled; data arriving into an occupied, stalled slot goes to the buffer; inst_req SHALL be 0 while the buffer is full; the buffer SHALL move into the slot on consumption, before any new data.
REQ-026 FETCH_INST_BUF_EN undefined: no buffer, and REQ-021 applies.

Structure
REQ-027 RESET_PC default, the FSM state encodings and the exception vector constants SHALL live in the shared CPU defines header.
REQ-028 The buffer SHALL be a sub-module fetch_buf (one-entry skid buffer), instantiated only under FETCH_INST_BUF_EN.

Verification
REQ-029 Reset release with addr_ok=1 and a data_ok latency of 1 -> inst_req rises 1 cycle after rst falls; addresses bfc00000, bfc00004, bfc00008; if_inst matches rdata in order.
REQ-030 br_taken=1 with br_target=bfc00100 in WAIT, with data_ok in the same cycle -> that data is dropped, the next inst_addr is bfc00100, and if_valid=0 for that cycle.
REQ-031 flush with flush_pc=bfc00380 while stall=1 and REQ+addr_ok in the same cycle -> DISCARD; the next data_ok is dropped; the next request is to bfc00380.
REQ-032 stall held for 5 cycles with if_valid=1 -> without the macro, inst_req=0 throughout; with the macro, exactly one extra word is buffered and delivered in order after stall falls.
REQ-033 Fetch pc at ffff_fffc -> the next address wraps to 0000_0000.
REQ-034 rst pulsed during WAIT -> BOOT, a stale data_ok is ignored, and fetch resumes at RESET_PC.
